// File: rtl/mem_port_b_arbiter_if.sv
// Port B bundle: three requester channels plus the BRAM port B pins.
// slave = arbiter side, master = requesters + memory side.
interface mem_port_b_arbiter_if #(
  parameter int unsigned ADDR_WIDTH = 12,
  parameter int unsigned DATA_WIDTH = 16
);
  logic                  r0_req;
  logic                  r0_we;
  logic [ADDR_WIDTH-1:0] r0_addr;
  logic [DATA_WIDTH-1:0] r0_wdata;
  logic                  r0_gnt;
  logic                  r0_rvalid;

  logic                  r1_req;
  logic                  r1_we;
  logic [ADDR_WIDTH-1:0] r1_addr;
  logic [DATA_WIDTH-1:0] r1_wdata;
  logic                  r1_gnt;
  logic                  r1_rvalid;

  logic                  r2_req;
  logic                  r2_we;
  logic [ADDR_WIDTH-1:0] r2_addr;
  logic [DATA_WIDTH-1:0] r2_wdata;
  logic                  r2_gnt;
  logic                  r2_rvalid;

  logic [DATA_WIDTH-1:0] rdata;
  logic [ADDR_WIDTH-1:0] mem_addr_b;
  logic [DATA_WIDTH-1:0] mem_din_b;
  logic                  mem_we_b;
  logic [DATA_WIDTH-1:0] mem_dout_b;
  logic                  wp_err;

  modport slave (
    input  r0_req, r0_we, r0_addr, r0_wdata,
    input  r1_req, r1_we, r1_addr, r1_wdata,
    input  r2_req, r2_we, r2_addr, r2_wdata,
    input  mem_dout_b,
    output r0_gnt, r0_rvalid, r1_gnt, r1_rvalid, r2_gnt, r2_rvalid,
    output rdata, mem_addr_b, mem_din_b, mem_we_b, wp_err
  );

  modport master (
    output r0_req, r0_we, r0_addr, r0_wdata,
    output r1_req, r1_we, r1_addr, r1_wdata,
    output r2_req, r2_we, r2_addr, r2_wdata,
    output mem_dout_b,
    input  r0_gnt, r0_rvalid, r1_gnt, r1_rvalid, r2_gnt, r2_rvalid,
    input  rdata, mem_addr_b, mem_din_b, mem_we_b, wp_err
  );
endinterface

// File: rtl/mem_port_b_arbiter.sv
// BRAM port B arbiter: r0 fixed priority, r1/r2 round-robin, registered grants.
// Optional write protection below PROT_LIMIT for r1/r2: define MEM_ARB_WPROT_EN.
module mem_port_b_arbiter #(
  parameter int unsigned           ADDR_WIDTH = 12,
  parameter int unsigned           DATA_WIDTH = 16,
  parameter logic [ADDR_WIDTH-1:0] PROT_LIMIT = 'h400
) (
  input logic           clk,
  input logic           reset,
  mem_port_b_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    SEL_NONE = 2'd0,
    SEL_R0   = 2'd1,
    SEL_R1   = 2'd2,
    SEL_R2   = 2'd3
  } sel_t;

  logic [2:0]            w_req;
  logic [2:0]            w_elig;
  sel_t                  w_sel;
  logic [2:0]            w_gnt_nxt;
  logic                  w_we;
  logic [ADDR_WIDTH-1:0] w_addr;
  logic [DATA_WIDTH-1:0] w_wdata;
  logic                  w_viol;

  logic [2:0]            r_gnt;
  logic [2:0]            r_gnt_rd;
  logic [2:0]            r_rvalid;
  logic                  r_rr_ptr;  // 0: r1 wins a tie, 1: r2 wins a tie
  logic [ADDR_WIDTH-1:0] r_mem_addr;
  logic [DATA_WIDTH-1:0] r_mem_din;
  logic                  r_mem_we;
  logic                  r_wp_err;

  assign w_req  = {bus.r2_req, bus.r1_req, bus.r0_req};
  // A requester holding gnt this cycle is masked so one req yields one grant.
  assign w_elig = w_req & ~r_gnt;

  always_comb begin
    w_sel = SEL_NONE;
    if (w_elig[0])
      w_sel = SEL_R0;
    else if (w_elig[1] && w_elig[2])
      w_sel = r_rr_ptr ? SEL_R2 : SEL_R1;
    else if (w_elig[1])
      w_sel = SEL_R1;
    else if (w_elig[2])
      w_sel = SEL_R2;
  end

  always_comb begin
    w_gnt_nxt = '0;
    w_we      = 1'b0;
    w_addr    = r_mem_addr;
    w_wdata   = r_mem_din;
    case (w_sel)
      SEL_R0: begin
        w_gnt_nxt = 3'b001;
        w_we      = bus.r0_we;
        w_addr    = bus.r0_addr;
        w_wdata   = bus.r0_wdata;
      end
      SEL_R1: begin
        w_gnt_nxt = 3'b010;
        w_we      = bus.r1_we;
        w_addr    = bus.r1_addr;
        w_wdata   = bus.r1_wdata;
      end
      SEL_R2: begin
        w_gnt_nxt = 3'b100;
        w_we      = bus.r2_we;
        w_addr    = bus.r2_addr;
        w_wdata   = bus.r2_wdata;
      end
      default: ;
    endcase
  end

`ifdef MEM_ARB_WPROT_EN
  logic w_low;
  assign w_low  = (w_sel == SEL_R1) || (w_sel == SEL_R2);
  assign w_viol = w_low && w_we && (w_addr < PROT_LIMIT);
`else
  logic w_unused_prot;
  assign w_unused_prot = ^PROT_LIMIT;
  assign w_viol        = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      r_gnt      <= '0;
      r_gnt_rd   <= '0;
      r_rvalid   <= '0;
      r_rr_ptr   <= 1'b0;
      r_mem_addr <= '0;
      r_mem_din  <= '0;
      r_mem_we   <= 1'b0;
      r_wp_err   <= 1'b0;
    end else begin
      r_gnt    <= w_gnt_nxt;
      r_gnt_rd <= w_we ? 3'b000 : w_gnt_nxt;
      r_rvalid <= r_gnt_rd;
      r_mem_we <= w_we & ~w_viol;
      r_wp_err <= w_viol;
      if (w_sel != SEL_NONE) begin
        r_mem_addr <= w_addr;
        r_mem_din  <= w_wdata;
      end
      if (w_sel == SEL_R1)
        r_rr_ptr <= 1'b1;
      else if (w_sel == SEL_R2)
        r_rr_ptr <= 1'b0;
    end
  end

  assign bus.r0_gnt     = r_gnt[0];
  assign bus.r1_gnt     = r_gnt[1];
  assign bus.r2_gnt     = r_gnt[2];
  assign bus.r0_rvalid  = r_rvalid[0];
  assign bus.r1_rvalid  = r_rvalid[1];
  assign bus.r2_rvalid  = r_rvalid[2];
  assign bus.rdata      = bus.mem_dout_b;
  assign bus.mem_addr_b = r_mem_addr;
  assign bus.mem_din_b  = r_mem_din;
  assign bus.mem_we_b   = r_mem_we;
  assign bus.wp_err     = r_wp_err;

endmodule

// File: tb/tb_mem_port_b_arbiter.sv
// Directed bench for mem_port_b_arbiter with a 1-cycle synchronous BRAM model.
module tb_mem_port_b_arbiter;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   n_chk = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  mem_port_b_arbiter_if #(.ADDR_WIDTH(12), .DATA_WIDTH(16)) bus ();

  mem_port_b_arbiter #(
    .ADDR_WIDTH(12),
    .DATA_WIDTH(16),
    .PROT_LIMIT(12'h400)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  // Read-first BRAM with registered output.
  logic [15:0] mem [0:4095];
  always @(posedge clk) begin
    bus.mem_dout_b <= mem[bus.mem_addr_b];
    if (bus.mem_we_b) mem[bus.mem_addr_b] = bus.mem_din_b;
  end

  typedef struct {
    logic        rst;
    logic [2:0]  req;
    logic [2:0]  exp_gnt;
    logic [2:0]  exp_rv;
    logic [11:0] exp_addr;
    logic        chk_rd;
    logic [15:0] exp_rdata;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [2:0] gnt3();
    return {bus.r2_gnt, bus.r1_gnt, bus.r0_gnt};
  endfunction

  function automatic logic [2:0] rv3();
    return {bus.r2_rvalid, bus.r1_rvalid, bus.r0_rvalid};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input logic [2:0] req, input logic [2:0] we);
    bus.r0_req = req[0]; bus.r1_req = req[1]; bus.r2_req = req[2];
    bus.r0_we  = we[0];  bus.r1_we  = we[1];  bus.r2_we  = we[2];
  endtask

  task automatic add(input logic rst, input logic [2:0] req, input logic [2:0] g,
                     input logic [2:0] rv, input logic [11:0] a, input logic crd,
                     input logic [15:0] d);
    vec_t v;
    v = '{rst, req, g, rv, a, crd, d};
    vecs.push_back(v);
  endtask

  initial begin
    for (int i = 0; i < 4096; i++) mem[i] = 16'h0000;
    mem[12'h010] = 16'hBEEF;
    mem[12'h020] = 16'h2020;
    mem[12'h030] = 16'h3030;
    bus.r0_addr = 12'h010; bus.r0_wdata = 16'h0000;
    bus.r1_addr = 12'h020; bus.r1_wdata = 16'h0000;
    bus.r2_addr = 12'h030; bus.r2_wdata = 16'h0000;
    set_req(3'b111, 3'b000);

    // rst, req, gnt, rvalid, mem_addr, check rdata, rdata
    add(1, 3'b111, 3'b000, 3'b000, 12'h000, 0, 16'h0000);
    add(1, 3'b111, 3'b000, 3'b000, 12'h000, 0, 16'h0000);
    add(1, 3'b111, 3'b000, 3'b000, 12'h000, 0, 16'h0000);
    add(0, 3'b111, 3'b001, 3'b000, 12'h010, 0, 16'h0000);
    add(0, 3'b111, 3'b010, 3'b001, 12'h020, 1, 16'hBEEF);
    add(0, 3'b111, 3'b001, 3'b010, 12'h010, 1, 16'h2020);
    add(0, 3'b111, 3'b100, 3'b001, 12'h030, 1, 16'hBEEF);
    add(0, 3'b111, 3'b001, 3'b100, 12'h010, 1, 16'h3030);
    add(0, 3'b111, 3'b010, 3'b001, 12'h020, 1, 16'hBEEF);
    add(0, 3'b111, 3'b001, 3'b010, 12'h010, 1, 16'h2020);
    add(0, 3'b000, 3'b000, 3'b001, 12'h010, 1, 16'hBEEF);
    add(0, 3'b000, 3'b000, 3'b000, 12'h010, 0, 16'h0000);
    add(0, 3'b111, 3'b001, 3'b000, 12'h010, 0, 16'h0000);
    add(1, 3'b111, 3'b000, 3'b000, 12'h000, 0, 16'h0000);
    add(0, 3'b111, 3'b001, 3'b000, 12'h010, 0, 16'h0000);
    add(0, 3'b111, 3'b010, 3'b001, 12'h020, 1, 16'hBEEF);
    add(0, 3'b000, 3'b000, 3'b010, 12'h020, 1, 16'h2020);

    for (int i = 0; i < vecs.size(); i++) begin
      reset = vecs[i].rst;
      set_req(vecs[i].req, 3'b000);
      step();
      chk($sformatf("vec%0d gnt", i), 32'(gnt3()), 32'(vecs[i].exp_gnt));
      chk($sformatf("vec%0d rvalid", i), 32'(rv3()), 32'(vecs[i].exp_rv));
      chk($sformatf("vec%0d mem_addr", i), 32'(bus.mem_addr_b), 32'(vecs[i].exp_addr));
      chk($sformatf("vec%0d mem_we", i), 32'(bus.mem_we_b), 32'd0);
      chk($sformatf("vec%0d wp_err", i), 32'(bus.wp_err), 32'd0);
      if (vecs[i].chk_rd)
        chk($sformatf("vec%0d rdata", i), 32'(bus.rdata), 32'(vecs[i].exp_rdata));
    end

    // r1 write 0x500 then r2 read back
    bus.r1_addr = 12'h500; bus.r1_wdata = 16'h1234; bus.r2_addr = 12'h500;
    set_req(3'b010, 3'b010);
    step();
    chk("wr gnt", 32'(gnt3()), 32'(3'b010));
    chk("wr mem_we", 32'(bus.mem_we_b), 32'd1);
    chk("wr mem_addr", 32'(bus.mem_addr_b), 32'h500);
    chk("wr mem_din", 32'(bus.mem_din_b), 32'h1234);
    set_req(3'b100, 3'b000);
    step();
    chk("rd gnt", 32'(gnt3()), 32'(3'b100));
    chk("rd mem_we", 32'(bus.mem_we_b), 32'd0);
    chk("wr no rvalid", 32'(rv3()), 32'(3'b000));
    set_req(3'b000, 3'b000);
    step();
    chk("rd rvalid", 32'(rv3()), 32'(3'b100));
    chk("rd rdata", 32'(bus.rdata), 32'h1234);

    // r1 and r2 continuous: strict alternation, rvalid trails gnt
    bus.r1_addr = 12'h020; bus.r2_addr = 12'h030;
    set_req(3'b110, 3'b000);
    for (int i = 0; i < 8; i++) begin
      step();
      chk($sformatf("rr%0d gnt", i), 32'(gnt3()), (i % 2 == 0) ? 32'(3'b010) : 32'(3'b100));
      if (i > 0) begin
        chk($sformatf("rr%0d rvalid", i), 32'(rv3()), (i % 2 == 0) ? 32'(3'b100) : 32'(3'b010));
        chk($sformatf("rr%0d rdata", i), 32'(bus.rdata), (i % 2 == 0) ? 32'h3030 : 32'h2020);
      end
    end
    set_req(3'b000, 3'b000);
    step();
    step();

    // single requester: one access every 2 cycles
    set_req(3'b001, 3'b000);
    for (int i = 0; i < 4; i++) begin
      step();
      chk($sformatf("solo%0d gnt", i), 32'(gnt3()), (i % 2 == 0) ? 32'(3'b001) : 32'(3'b000));
    end
    set_req(3'b000, 3'b000);
    step();
    step();

    // r1 withdraws a write before ever being granted
    bus.r1_addr = 12'h600; bus.r1_wdata = 16'hDEAD;
    set_req(3'b011, 3'b010);
    step();
    chk("wd gnt", 32'(gnt3()), 32'(3'b001));
    set_req(3'b000, 3'b000);
    for (int i = 0; i < 2; i++) begin
      step();
      chk($sformatf("wd%0d gnt", i), 32'(gnt3()), 32'(3'b000));
      chk($sformatf("wd%0d mem_we", i), 32'(bus.mem_we_b), 32'd0);
    end
    chk("wd mem untouched", 32'(mem[12'h600]), 32'h0000);

    // r2 writes straddling the protection limit, then an r0 low write
    bus.r2_addr = 12'h3FF; bus.r2_wdata = 16'hAAAA;
    set_req(3'b100, 3'b100);
    step();
    chk("wp lo gnt", 32'(gnt3()), 32'(3'b100));
`ifdef MEM_ARB_WPROT_EN
    chk("wp lo mem_we", 32'(bus.mem_we_b), 32'd0);
    chk("wp lo wp_err", 32'(bus.wp_err), 32'd1);
`else
    chk("wp lo mem_we", 32'(bus.mem_we_b), 32'd1);
    chk("wp lo wp_err", 32'(bus.wp_err), 32'd0);
`endif
    set_req(3'b000, 3'b000);
    step();
    chk("wp idle wp_err", 32'(bus.wp_err), 32'd0);
    bus.r2_addr = 12'h400;
    set_req(3'b100, 3'b100);
    step();
    chk("wp hi gnt", 32'(gnt3()), 32'(3'b100));
    chk("wp hi mem_we", 32'(bus.mem_we_b), 32'd1);
    chk("wp hi wp_err", 32'(bus.wp_err), 32'd0);
    bus.r0_addr = 12'h100; bus.r0_wdata = 16'h5555;
    set_req(3'b001, 3'b001);
    step();
    chk("wp r0 gnt", 32'(gnt3()), 32'(3'b001));
    chk("wp r0 mem_we", 32'(bus.mem_we_b), 32'd1);
    chk("wp r0 wp_err", 32'(bus.wp_err), 32'd0);
    set_req(3'b000, 3'b000);
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_port_b_arbiter.md
Name: mem_port_b_arbiter

Overview:
- Arbitrates port B of the shared program/data block RAM among three requesters: r0 (VGA/display fetch, fixed highest priority), r1 (SNES input writer) and r2 (debug/DMA loader).
- Port A stays owned by the CPU control FSM.
- Issues at most one access per cycle and returns read data with BRAM latency.
- Grants and memory-side outputs are registered.

Parameters:
- ADDR_WIDTH, 12, memory word address width.
- DATA_WIDTH, 16, memory word width.
- PROT_LIMIT, 12'h400, first address writable by r1/r2 (used only with the optional feature).

Ports:
- clk  input  1  clock.
- reset  input  1  synchronous, active-high reset.
- rN_req  input  1  access request, N=0..2; held with addr/we/wdata stable until rN_gnt.
- rN_we  input  1  1 = write, 0 = read.
- rN_addr  input  ADDR_WIDTH  word address.
- rN_wdata  input  DATA_WIDTH  write data.
- rN_gnt  output  1  one-cycle pulse: access is being presented to memory this cycle.
- rN_rvalid  output  1  one-cycle pulse, cycle after a read grant; rdata valid.
- rdata  output  DATA_WIDTH  mem_dout_b passthrough, shared by all requesters.
- mem_addr_b  output  ADDR_WIDTH  BRAM port B address.
- mem_din_b  output  DATA_WIDTH  BRAM port B write data.
- mem_we_b  output  1  BRAM port B write enable.
- mem_dout_b  input  DATA_WIDTH  BRAM port B read data, 1-cycle synchronous read.
- wp_err  output  1  write-protect violation pulse (optional feature; tied 0 otherwise).

Behaviour:
- Reset (sync, active-high):
  - All rN_gnt, rN_rvalid, mem_we_b and wp_err are 0.
  - mem_addr_b and mem_din_b are 0.
  - rr_ptr selects r1.
  - Reset asserted mid-operation drops any pending rvalid; no memory write is issued in the reset cycle or the cycle after it.
- Arbitration runs every rising edge.
  - Eligible set: rN_req=1 AND rN_gnt currently 0. A requester being granted this cycle is masked, so one req can never yield two grants.
  - r0 eligible -> grant r0.
  - Otherwise r1/r2: if both are eligible, grant rr_ptr's choice; if one is eligible, grant it.
  - rr_ptr flips to the other low-priority requester after any r1 or r2 grant. It is unchanged on r0 grants and idle cycles.
- Grant cycle (registered from the edge decision):
  - rN_gnt=1.
  - mem_addr_b=rN_addr, mem_we_b=rN_we, mem_din_b=rN_wdata.
- Read return: the cycle after a read grant, rN_rvalid=1 and rdata=mem_dout_b. A write grant produces no rvalid.
- Idle cycle (no eligible requester):
  - gnt all 0 and mem_we_b=0.
  - mem_addr_b and mem_din_b hold their last values.
- Throughput:
  - Aggregate: 1 access/cycle.
  - Single requester: 1 access per 2 cycles, because of masking.
  - A requester keeping req high after gnt is treated as a new request at the next edge.
- Back-to-back grant to r1 at t and r2 at t+1: both rvalids issue in order, one per cycle. rvalids never overlap.
- Requester dropping req before gnt: the request is withdrawn with no side effect.
- All three continuously requesting: grant sequence r0,r1,r0,r2,r0,r1,... Worst-case r1/r2 wait is 4 cycles.
- Address arithmetic: no wrap or translation; addresses pass through unchanged.

Optional Feature:
- Macro: MEM_ARB_WPROT_EN.
- Defined:
  - A write granted to r1 or r2 with addr < PROT_LIMIT is still granted (rN_gnt pulses).
  - mem_we_b is forced 0 for that access and wp_err pulses 1 in the grant cycle.
  - r0 writes and all reads are unaffected.
- Undefined: no address check; wp_err is tied 0; PROT_LIMIT is unused.

Test Plan:
1. Hold reset 3 cycles with all reqs high -> all gnt/rvalid/mem_we_b/wp_err 0 and mem_addr_b=0; first grant goes to r0 on the edge after reset deasserts.
2. r0 read 0x010 alone, BRAM[0x010]=16'hBEEF -> r0_gnt with mem_addr_b=0x010 and mem_we_b=0; next cycle r0_rvalid=1 and rdata=16'hBEEF.
3. r1 write 0x500 data 16'h1234, then r2 read 0x500 -> r1_gnt with mem_we_b=1, then r2_gnt; next cycle r2_rvalid and rdata=16'h1234.
4. r1 and r2 requesting continuously for 8 cycles -> grants alternate r1,r2,r1,r2 with no cycle granting both.
5. r0, r1, r2 all continuously requesting -> grant sequence r0,r1,r0,r2,r0,r1; each read rvalid follows its gnt by exactly 1 cycle.
6. MEM_ARB_WPROT_EN defined, r2 writes 0x3FF then 0x400 -> first: r2_gnt, mem_we_b=0, wp_err=1; second: mem_we_b=1, wp_err=0.
